// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract unit: adds one CHUNK-bit slice per cycle, carry rippled through a register.
// Optional signed-overflow output is enabled by defining ADDER_OVERFLOW_EN.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_output_bit
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("chunked_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q, sum_q;
  logic [WIDTH-1:0] sum_d, x_shift, y_shift;
  logic [CW-1:0]    idx_q;
  logic             carry_q, cout_q, in_ready_q, out_valid_q;
  logic [CHUNK:0]   slice_sum;
  logic             last_slice;

  // Operands shift down each ADD cycle, so the active slice is always the low CHUNK bits.
  assign slice_sum  = {1'b0, x_q[CHUNK-1:0]} + {1'b0, y_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign last_slice = (idx_q == CW'(NCHUNK - 1));

  generate
    if (NCHUNK > 1) begin : g_shift
      assign x_shift = {{CHUNK{1'b0}}, x_q[WIDTH-1:CHUNK]};
      assign y_shift = {{CHUNK{1'b0}}, y_q[WIDTH-1:CHUNK]};
    end else begin : g_noshift
      assign x_shift = x_q;
      assign y_shift = y_q;
    end

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign sum_d[gi*CHUNK +: CHUNK] = (state_q == ADD && idx_q == CW'(gi))
                                        ? slice_sum[CHUNK-1:0]
                                        : sum_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

`ifdef ADDER_OVERFLOW_EN
  // Operand MSBs are kept separately because x_q/y_q are consumed by the shift.
  logic x_msb_q, y_msb_q, ovf_q;
  assign overflow = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
`ifdef ADDER_OVERFLOW_EN
      x_msb_q     <= 1'b0;
      y_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= x;
            y_q        <= sub ? ~y : y;
            carry_q    <= sub | carry_in;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ADD;
`ifdef ADDER_OVERFLOW_EN
            x_msb_q    <= x[WIDTH-1];
            y_msb_q    <= sub ? ~y[WIDTH-1] : y[WIDTH-1];
`endif
          end
        end
        ADD: begin
          sum_q   <= sum_d;
          carry_q <= slice_sum[CHUNK];
          x_q     <= x_shift;
          y_q     <= y_shift;
          idx_q   <= idx_q + CW'(1);
          if (last_slice) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            cout_q      <= slice_sum[CHUNK];
`ifdef ADDER_OVERFLOW_EN
            ovf_q       <= (x_msb_q == y_msb_q) && (sum_d[WIDTH-1] != x_msb_q);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign sum              = sum_q;
  assign carry_output_bit = cout_q;

endmodule
